// File: rtl/drv_led_sense_mux.sv
// rtl/drv_led_sense_mux.sv - drive-bay LED drive / strap sense pin time-multiplexer
// Scans all bays each PERIOD: drive LEDs, release pins, then sample and debounce the straps.
module drv_led_sense_mux #(
    parameter int N_DRV   = 36,
    parameter int PERIOD  = 2500000,
    parameter int RELEASE = 25000,
    parameter int DEB_CNT = 3
) (
    input  logic             SYSCLK,
    input  logic             RESET_N,
    input  logic             SCAN_EN,
    input  logic [N_DRV-1:0] AMBER_DAT,
    input  logic [N_DRV-1:0] BLUE_DAT,
    input  logic [N_DRV-1:0] AMBER_I,
    input  logic [N_DRV-1:0] BLUE_I,
    output logic [N_DRV-1:0] AMBER_O,
    output logic [N_DRV-1:0] BLUE_O,
    output logic [N_DRV-1:0] PIN_OE,
    input  logic [N_DRV-1:0] CHG_CLR,
    output logic [N_DRV-1:0] PRSNT,
    output logic [N_DRV-1:0] IDENT,
    output logic [N_DRV-1:0] PRSNT_CHG,
    output logic             CHG_IRQ,
    output logic             SAMPLE_STB
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DW = 4;
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0] CNT_REL  = CW'(PERIOD - RELEASE);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pin_oe_q, pin_oe_d;
    logic [N_DRV-1:0] amber_o_q, amber_o_d;
    logic [N_DRV-1:0] blue_o_q, blue_o_d;
    logic [N_DRV-1:0] amber_s1_q, amber_s1_d, amber_s2_q, amber_s2_d;
    logic [N_DRV-1:0] blue_s1_q, blue_s1_d, blue_s2_q, blue_s2_d;
    logic [N_DRV-1:0] prsnt_q, prsnt_d;
    logic [N_DRV-1:0] ident_q, ident_d;
    logic [N_DRV-1:0] chg_q, chg_d;
    logic             irq_q, irq_d;
    logic [DW-1:0]    pdeb_q [N_DRV];
    logic [DW-1:0]    pdeb_d [N_DRV];
    logic [DW-1:0]    ideb_q [N_DRV];
    logic [DW-1:0]    ideb_d [N_DRV];
    logic             sample;

    // Returns {stable, counter} after one sample of a single strap.
    function automatic logic [DW:0] deb_next(input logic raw, input logic stable,
                                             input logic [DW-1:0] cnt);
        logic [DW:0] r;
        if (raw == stable) begin
            r = {stable, {DW{1'b0}}};
        end else if (cnt >= DEB_LAST) begin
            r = {raw, {DW{1'b0}}};
        end else begin
            r = {stable, cnt + DW'(1)};
        end
        return r;
    endfunction

    always_comb begin
        sample = SCAN_EN && (cnt_q == CNT_LAST);

        cnt_d = '0;
        if (SCAN_EN && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end

        // Output enable and LED data are computed from the next count so they line up with CNT.
        pin_oe_d  = SCAN_EN && (cnt_d < CNT_REL);
        amber_o_d = pin_oe_d ? AMBER_DAT : amber_o_q;
        blue_o_d  = pin_oe_d ? BLUE_DAT  : blue_o_q;

        amber_s1_d = AMBER_I;
        amber_s2_d = amber_s1_q;
        blue_s1_d  = BLUE_I;
        blue_s2_d  = blue_s1_q;

        prsnt_d = prsnt_q;
        ident_d = ident_q;
        pdeb_d  = pdeb_q;
        ideb_d  = ideb_q;
        if (!SCAN_EN) begin
            for (int k = 0; k < N_DRV; k++) begin
                pdeb_d[k] = '0;
                ideb_d[k] = '0;
            end
        end else if (sample) begin
            for (int k = 0; k < N_DRV; k++) begin
                {prsnt_d[k], pdeb_d[k]} = deb_next(~blue_s2_q[k], prsnt_q[k], pdeb_q[k]);
                {ident_d[k], ideb_d[k]} = deb_next(amber_s2_q[k], ident_q[k], ideb_q[k]);
            end
        end

        // A toggle on the same edge as a clear keeps the flag set.
        chg_d = (chg_q & ~CHG_CLR) | (prsnt_d ^ prsnt_q);
        irq_d = |chg_q;
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q      <= '0;
            pin_oe_q   <= 1'b0;
            amber_o_q  <= '0;
            blue_o_q   <= '0;
            amber_s1_q <= '0;
            amber_s2_q <= '0;
            blue_s1_q  <= '0;
            blue_s2_q  <= '0;
            prsnt_q    <= '0;
            ident_q    <= '0;
            chg_q      <= '0;
            irq_q      <= 1'b0;
            pdeb_q     <= '{default: '0};
            ideb_q     <= '{default: '0};
        end else begin
            cnt_q      <= cnt_d;
            pin_oe_q   <= pin_oe_d;
            amber_o_q  <= amber_o_d;
            blue_o_q   <= blue_o_d;
            amber_s1_q <= amber_s1_d;
            amber_s2_q <= amber_s2_d;
            blue_s1_q  <= blue_s1_d;
            blue_s2_q  <= blue_s2_d;
            prsnt_q    <= prsnt_d;
            ident_q    <= ident_d;
            chg_q      <= chg_d;
            irq_q      <= irq_d;
            pdeb_q     <= pdeb_d;
            ideb_q     <= ideb_d;
        end
    end

    assign AMBER_O    = amber_o_q;
    assign BLUE_O     = blue_o_q;
    assign PIN_OE     = {N_DRV{pin_oe_q}};
    assign PRSNT      = prsnt_q;
    assign IDENT      = ident_q;
    assign PRSNT_CHG  = chg_q;
    assign CHG_IRQ    = irq_q;
    assign SAMPLE_STB = sample;

endmodule

// File: tb/tb_drv_led_sense_mux.sv
// tb/tb_drv_led_sense_mux.sv - self-checking bench for drv_led_sense_mux
// Directed steps followed by random traffic, checked every cycle against a period-level model.
module tb_drv_led_sense_mux;

    localparam int N = 4;
    localparam int P = 20;
    localparam int R = 5;
    localparam int D = 3;

    logic         SYSCLK = 1'b0;
    logic         RESET_N;
    logic         SCAN_EN;
    logic [N-1:0] AMBER_DAT, BLUE_DAT, AMBER_I, BLUE_I, CHG_CLR;
    logic [N-1:0] AMBER_O, BLUE_O, PIN_OE, PRSNT, IDENT, PRSNT_CHG;
    logic         CHG_IRQ, SAMPLE_STB;

    always #5 SYSCLK = ~SYSCLK;

    drv_led_sense_mux #(.N_DRV(N), .PERIOD(P), .RELEASE(R), .DEB_CNT(D)) dut (
        .SYSCLK(SYSCLK), .RESET_N(RESET_N), .SCAN_EN(SCAN_EN),
        .AMBER_DAT(AMBER_DAT), .BLUE_DAT(BLUE_DAT),
        .AMBER_I(AMBER_I), .BLUE_I(BLUE_I),
        .AMBER_O(AMBER_O), .BLUE_O(BLUE_O), .PIN_OE(PIN_OE),
        .CHG_CLR(CHG_CLR), .PRSNT(PRSNT), .IDENT(IDENT),
        .PRSNT_CHG(PRSNT_CHG), .CHG_IRQ(CHG_IRQ), .SAMPLE_STB(SAMPLE_STB)
    );

    int total = 0;
    int bad   = 0;

    int           pos;
    logic         m_oe, m_irq;
    logic [N-1:0] m_amber, m_blue, m_prsnt, m_ident, m_chg;
    logic [N-1:0] p_hist[$];
    logic [N-1:0] i_hist[$];
    int           since_p[N];
    int           since_i[N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pos = 0; m_oe = 0; m_irq = 0;
        m_amber = '0; m_blue = '0; m_prsnt = '0; m_ident = '0; m_chg = '0;
        p_hist.delete(); i_hist.delete();
        for (int k = 0; k < N; k++) begin since_p[k] = 0; since_i[k] = 0; end
    endtask

    // A strap value is accepted once the last D samples since the previous
    // acceptance (or scan stop) all disagree with the current stable value.
    task automatic model_sample(input logic [N-1:0] praw, input logic [N-1:0] iraw,
                                output logic [N-1:0] np, output logic [N-1:0] ni);
        bit fp, fi;
        p_hist.push_back(praw);
        i_hist.push_back(iraw);
        if (p_hist.size() > 16) void'(p_hist.pop_front());
        if (i_hist.size() > 16) void'(i_hist.pop_front());
        np = m_prsnt;
        ni = m_ident;
        for (int k = 0; k < N; k++) begin
            since_p[k]++;
            since_i[k]++;
            fp = (since_p[k] >= D);
            fi = (since_i[k] >= D);
            for (int j = 1; j <= D; j++) begin
                if (fp && p_hist[p_hist.size() - j][k] == m_prsnt[k]) fp = 0;
                if (fi && i_hist[i_hist.size() - j][k] == m_ident[k]) fi = 0;
            end
            if (fp) begin np[k] = ~m_prsnt[k]; since_p[k] = 0; end
            if (fi) begin ni[k] = ~m_ident[k]; since_i[k] = 0; end
        end
    endtask

    task automatic check_all();
        chk("pin_oe", PIN_OE, {N{m_oe}});
        chk("amber_o", AMBER_O, m_amber);
        chk("blue_o", BLUE_O, m_blue);
        chk("sample_stb", SAMPLE_STB, (SCAN_EN && pos == P - 1));
        chk("prsnt", PRSNT, m_prsnt);
        chk("ident", IDENT, m_ident);
        chk("prsnt_chg", PRSNT_CHG, m_chg);
        chk("chg_irq", CHG_IRQ, m_irq);
    endtask

    // One clock: predict from the inputs presented at the edge, then compare.
    task automatic tick();
        logic         en;
        logic [N-1:0] clr, ad, bd, np, ni;
        en = SCAN_EN; clr = CHG_CLR; ad = AMBER_DAT; bd = BLUE_DAT;
        np = m_prsnt; ni = m_ident;
        if (en && pos == P - 1) model_sample(~BLUE_I, AMBER_I, np, ni);
        if (!en) begin
            for (int k = 0; k < N; k++) begin since_p[k] = 0; since_i[k] = 0; end
        end
        m_irq   = |m_chg;
        m_chg   = (m_chg & ~clr) | (np ^ m_prsnt);
        m_prsnt = np;
        m_ident = ni;
        pos     = en ? (pos + 1) % P : 0;
        m_oe    = en && (pos < P - R);
        if (m_oe) begin m_amber = ad; m_blue = bd; end
        @(posedge SYSCLK);
        #1;
        check_all();
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < P && pos != target; i++) tick();
    endtask

    initial begin
        RESET_N = 0; SCAN_EN = 1;
        AMBER_DAT = '0; BLUE_DAT = '0; AMBER_I = '0; BLUE_I = '1; CHG_CLR = '0;
        model_reset();

        // reset state
        repeat (3) begin
            @(posedge SYSCLK);
            #1;
            chk("rst_oe", PIN_OE, 4'h0);
            chk("rst_prsnt", PRSNT, 4'h0);
            chk("rst_stb", SAMPLE_STB, 1'b0);
            check_all();
        end
        RESET_N = 1;
        repeat (P - 1) tick();
        chk("first_stb", SAMPLE_STB, 1'b1);

        // drive / release phases
        AMBER_DAT = 4'hA; BLUE_DAT = 4'h5;
        run_to(5);
        chk("drive_oe", PIN_OE, 4'hF);
        chk("drive_amber", AMBER_O, 4'hA);
        chk("drive_blue", BLUE_O, 4'h5);
        run_to(16);
        chk("rel_oe", PIN_OE, 4'h0);
        AMBER_DAT = 4'h3;
        run_to(19);
        chk("rel_hold", AMBER_O, 4'hA);

        // bay 0 inserted
        run_to(0);
        BLUE_I = 4'hE;
        repeat (2 * P) tick();
        chk("prsnt_2smp", PRSNT, 4'h0);
        repeat (P) tick();
        chk("prsnt_3smp", PRSNT, 4'h1);
        chk("chg_set", PRSNT_CHG, 4'h1);
        chk("irq_lag0", CHG_IRQ, 1'b0);
        tick();
        chk("irq_lag1", CHG_IRQ, 1'b1);

        // short glitch on bay 1 is rejected
        BLUE_I = 4'hC;
        repeat (2 * P) tick();
        BLUE_I = 4'hE;
        repeat (2 * P) tick();
        chk("glitch_prsnt", PRSNT, 4'h1);
        chk("glitch_chg", PRSNT_CHG, 4'h1);

        // set beats clear on the same edge, then explicit clear
        BLUE_I = 4'hA;
        repeat (2 * P) tick();
        run_to(19);
        CHG_CLR = 4'h4;
        tick();
        CHG_CLR = 4'h0;
        chk("setwin_prsnt", PRSNT, 4'h5);
        chk("setwin_chg", PRSNT_CHG, 4'h5);
        CHG_CLR = 4'h5;
        tick();
        CHG_CLR = 4'h0;
        chk("clr_chg", PRSNT_CHG, 4'h0);
        chk("clr_irq_lag", CHG_IRQ, 1'b1);
        tick();
        chk("clr_irq", CHG_IRQ, 1'b0);

        // scan stop mid-period and restart
        run_to(7);
        SCAN_EN = 0;
        tick();
        chk("stop_oe", PIN_OE, 4'h0);
        repeat (25) tick();
        chk("stop_prsnt", PRSNT, 4'h5);
        SCAN_EN = 1;
        repeat (P - 2) tick();
        chk("restart_nostb", SAMPLE_STB, 1'b0);
        tick();
        chk("restart_stb", SAMPLE_STB, 1'b1);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            AMBER_DAT = N'($urandom);
            BLUE_DAT  = N'($urandom);
            CHG_CLR   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            if (pos == 2 && $urandom_range(0, 2) == 0) begin
                BLUE_I  = N'($urandom);
                AMBER_I = N'($urandom);
            end
            if (SCAN_EN) begin
                if ($urandom_range(0, 99) == 0) SCAN_EN = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                SCAN_EN = 1;
            end
            tick();
        end
        CHG_CLR = '0;

        // asynchronous reset mid-operation
        SCAN_EN = 1;
        run_to(5);
        RESET_N = 0;
        #2;
        chk("arst_oe", PIN_OE, 4'h0);
        chk("arst_amber", AMBER_O, 4'h0);
        chk("arst_prsnt", PRSNT, 4'h0);
        chk("arst_chg", PRSNT_CHG, 4'h0);
        chk("arst_irq", CHG_IRQ, 1'b0);
        model_reset();
        @(posedge SYSCLK);
        #1;
        check_all();
        RESET_N = 1;
        repeat (P) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
